// File: rtl/rb_sequencer.sv
// rb_sequencer: microprogram sequencer for the 16x8 register bank and its ALU.
// Fetches from a synchronous ROM; every instruction runs FETCH, DECODE, EXEC.
module rb_sequencer #(
   parameter int PC_W = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [15:0]     instr,
   input  logic [7:0]      ALUout,
   output logic [PC_W-1:0] pc,
   output logic [2:0]      InMuxAdd,
   output logic [3:0]      OutMuxAdd,
   output logic [3:0]      RegAdd,
   output logic            WE,
   output logic [7:0]      CUconst,
   output logic [3:0]      ALUsel,
   output logic            busy,
   output logic            done,
   output logic            illegal
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_DONE
   } state_t;

   localparam logic [3:0] OP_LDA  = 4'h1;
   localparam logic [3:0] OP_LDB  = 4'h2;
   localparam logic [3:0] OP_LDI  = 4'h3;
   localparam logic [3:0] OP_MOV  = 4'h4;
   localparam logic [3:0] OP_ALU  = 4'h5;
   localparam logic [3:0] OP_JMP  = 4'h6;
   localparam logic [3:0] OP_JZ   = 4'h7;
   localparam logic [3:0] OP_HALT = 4'hF;

   state_t     state;
   logic [3:0] ir_op;
   logic [7:0] ir_imm;
   logic       z;
   logic [3:0] op;

   assign op = instr[15:12];

   // Bank controls are loaded on the same edge as IR, so during EXEC they equal
   // the decode of IR and they hold their value outside EXEC.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         pc        <= '0;
         ir_op     <= '0;
         ir_imm    <= '0;
         z         <= 1'b0;
         InMuxAdd  <= '0;
         OutMuxAdd <= '0;
         RegAdd    <= '0;
         CUconst   <= '0;
         ALUsel    <= '0;
         WE        <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         // NOTE: WE is a one-cycle registered strobe; clearing it by default confines it to EXEC.
         WE <= 1'b0;
         unique case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state   <= S_FETCH;
                  pc      <= '0;
                  z       <= 1'b0;
                  illegal <= 1'b0;
                  busy    <= 1'b1;
                  done    <= 1'b0;
               end
            end
            S_FETCH: state <= S_DECODE;
            S_DECODE: begin
               state     <= S_EXEC;
               ir_op     <= op;
               ir_imm    <= instr[7:0];
               RegAdd    <= instr[11:8];
               OutMuxAdd <= instr[3:0];
               ALUsel    <= instr[3:0];
               CUconst   <= instr[7:0];
               WE        <= (op >= OP_LDA) && (op <= OP_ALU);
               if ((op > OP_JZ) && (op < OP_HALT)) illegal <= 1'b1;
               case (op)
                  OP_LDA:  InMuxAdd <= 3'd0;
                  OP_LDB:  InMuxAdd <= 3'd1;
                  OP_LDI:  InMuxAdd <= 3'd2;
                  OP_ALU:  InMuxAdd <= 3'd3;
                  OP_MOV:  InMuxAdd <= 3'd4;
                  default: ;
               endcase
            end
            S_EXEC: begin
               if (ir_op == OP_ALU) z <= (ALUout == 8'd0);
               if (ir_op == OP_HALT) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state <= S_FETCH;
                  if ((ir_op == OP_JMP) || ((ir_op == OP_JZ) && z))
                     pc <= PC_W'(ir_imm);
                  else
                     pc <= pc + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rb_sequencer.sv
// Self-checking bench for rb_sequencer: instruction-level model with per-cycle
// expectations, a behavioural register bank, and directed program vectors.
module tb_rb_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, start4;
   logic [15:0] instr8, instr4;
   logic [7:0]  alu_val, in_a, in_b;

   logic [7:0] pc8;
   logic [2:0] im8;
   logic [3:0] om8, ra8, as8;
   logic [7:0] cu8;
   logic       we8, busy8, done8, ill8;

   logic [3:0] pc4;
   logic [2:0] im4;
   logic [3:0] om4, ra4, as4;
   logic [7:0] cu4;
   logic       we4, busy4, done4, ill4;

   rb_sequencer #(.PC_W(8)) u8 (
      .clk(clk), .reset(reset), .start(start), .instr(instr8), .ALUout(alu_val),
      .pc(pc8), .InMuxAdd(im8), .OutMuxAdd(om8), .RegAdd(ra8), .WE(we8),
      .CUconst(cu8), .ALUsel(as8), .busy(busy8), .done(done8), .illegal(ill8)
   );

   rb_sequencer #(.PC_W(4)) u4 (
      .clk(clk), .reset(reset), .start(start4), .instr(instr4), .ALUout(alu_val),
      .pc(pc4), .InMuxAdd(im4), .OutMuxAdd(om4), .RegAdd(ra4), .WE(we4),
      .CUconst(cu4), .ALUsel(as4), .busy(busy4), .done(done4), .illegal(ill4)
   );

   // Synchronous program ROMs
   logic [15:0] rom8 [256];
   logic [15:0] rom4 [16];
   always @(posedge clk) begin
      instr8 <= rom8[pc8];
      instr4 <= rom4[pc4];
   end

   // Register bank driven by the sequencer
   logic [7:0] bank  [16] = '{default: 8'h00};
   logic [7:0] mregs [16] = '{default: 8'h00};
   logic [7:0] bank_in;
   always_comb begin
      bank_in = 8'h00;
      case (im8)
         3'd0: bank_in = in_a;
         3'd1: bank_in = in_b;
         3'd2: bank_in = cu8;
         3'd3: bank_in = alu_val;
         3'd4: bank_in = bank[om8];
         default: bank_in = 8'h00;
      endcase
   end
   always @(posedge clk) if (we8) bank[ra8] <= bank_in;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [7:0] pc;
      logic       busy;
      logic       done;
      logic       we;
      logic       ill;
      logic [3:0] rd;
      logic [2:0] mux;
      logic       chk_cu;
      logic [7:0] cu;
      logic       chk_om;
      logic [3:0] om;
      logic       chk_alu;
      logic [3:0] alu;
   } exp_t;

   exp_t q[$];

   // Instruction-level model: expands each executed instruction into its three
   // cycles and the run into a final DONE cycle.
   task automatic model_run();
      logic [7:0]  p;
      logic [15:0] w;
      logic [3:0]  opc, d, s;
      logic        zf, il;
      exp_t        e;
      p  = 8'h00;
      zf = 1'b0;
      il = 1'b0;
      for (int k = 0; k < 300; k++) begin
         w   = rom8[p];
         opc = w[15:12];
         d   = w[11:8];
         s   = w[3:0];
         e      = '0;
         e.pc   = p;
         e.busy = 1'b1;
         e.ill  = il;
         q.push_back(e);
         q.push_back(e);
         if (opc >= 4'h8 && opc <= 4'hE) il = 1'b1;
         e.ill = il;
         e.we  = (opc >= 4'h1 && opc <= 4'h5);
         e.rd  = d;
         case (opc)
            4'h1: begin e.mux = 3'd0; mregs[d] = in_a; end
            4'h2: begin e.mux = 3'd1; mregs[d] = in_b; end
            4'h3: begin e.mux = 3'd2; e.chk_cu = 1'b1; e.cu = w[7:0]; mregs[d] = w[7:0]; end
            4'h4: begin e.mux = 3'd4; e.chk_om = 1'b1; e.om = s; mregs[d] = mregs[s]; end
            4'h5: begin e.mux = 3'd3; e.chk_alu = 1'b1; e.alu = s; mregs[d] = alu_val;
                        zf = (alu_val == 8'h00); end
            default: ;
         endcase
         q.push_back(e);
         if (opc == 4'hF) begin
            e      = '0;
            e.pc   = p;
            e.done = 1'b1;
            e.ill  = il;
            q.push_back(e);
            return;
         end
         if (opc == 4'h6 || (opc == 4'h7 && zf)) p = w[7:0];
         else p = p + 8'h01;
      end
      check("model_no_halt", 32'd1, 32'd0);
   endtask

   always @(negedge clk) begin : cmp
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         check("pc", pc8, e.pc);
         check("busy", busy8, e.busy);
         check("done", done8, e.done);
         check("we", we8, e.we);
         check("illegal", ill8, e.ill);
         if (e.we) begin
            check("regadd", ra8, e.rd);
            check("inmux", im8, e.mux);
            if (e.chk_cu)  check("cuconst", cu8, e.cu);
            if (e.chk_om)  check("outmux", om8, e.om);
            if (e.chk_alu) check("alusel", as8, e.alu);
         end
      end
   end

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom8[i] = 16'h0000;
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 16; i++) check($sformatf("%s_r%0d", tag, i), bank[i], mregs[i]);
   endtask

   // mode 0: single start pulse; 1: start held until a second run begins; 2: extra pulse while busy
   task automatic run_prog(input string tag, input int mode, output int lat, output int wes);
      int n, n2;
      lat = 0;
      wes = 0;
      @(negedge clk);
      #1;
      model_run();
      n2 = q.size();
      if (mode == 1) begin
         model_run();
         n2 = q.size() - n2;
      end
      start = 1'b1;
      n = 0;
      while (n < 400) begin
         @(negedge clk);
         #1;
         n++;
         if (mode != 1 || q.size() < n2) start = 1'b0;
         if (mode == 2 && n == 5) start = 1'b1;
         if (we8) wes++;
         if (done8 && lat == 0) lat = n - 1; // done seen n negedges after the sampling edge
         if (q.size() == 0) break;
      end
      start = 1'b0;
      if (q.size() != 0) begin
         check({tag, "_timeout"}, 32'd1, 32'd0);
         q.delete();
      end
      check_regs(tag);
   endtask

   initial begin
      int lat, wes, n;
      int seq[$];
      logic [3:0] last;
      reset  = 1'b0;
      start  = 1'b0;
      start4 = 1'b0;
      alu_val = 8'h00;
      in_a   = 8'h00;
      in_b   = 8'h00;
      clear_rom();
      for (int i = 0; i < 16; i++) rom4[i] = 16'h0000;

      // Reset state
      #12;
      check("rst_pc", pc8, 8'h00);
      check("rst_we", we8, 1'b0);
      check("rst_busy", busy8, 1'b0);
      check("rst_done", done8, 1'b0);
      check("rst_illegal", ill8, 1'b0);
      check("rst_inmux", im8, 3'd0);
      check("rst_outmux", om8, 4'd0);
      check("rst_regadd", ra8, 4'd0);
      check("rst_cuconst", cu8, 8'h00);
      check("rst_alusel", as8, 4'd0);
      @(negedge clk);
      #1 reset = 1'b1;

      // T1: reset dropped while the LDI write strobe is high
      rom8[0] = 16'h37AA;
      rom8[1] = 16'hF000;
      @(negedge clk);
      #1 start = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         #1 start = 1'b0;
         n++;
      end while (!we8 && n < 10);
      check("t1_we_seen", we8, 1'b1);
      reset = 1'b0;
      #1;
      check("t1_we", we8, 1'b0);
      check("t1_pc", pc8, 8'h00);
      check("t1_busy", busy8, 1'b0);
      check("t1_done", done8, 1'b0);
      @(posedge clk);
      #1;
      check("t1_r7", bank[7], 8'h00);
      @(negedge clk);
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      check("t1_idle_busy", busy8, 1'b0);
      check("t1_idle_pc", pc8, 8'h00);

      // T2: LDI R1,5; LDI R2,3; ALU R0,ADD; HALT
      clear_rom();
      rom8[0] = 16'h3105;
      rom8[1] = 16'h3203;
      rom8[2] = 16'h5000;
      rom8[3] = 16'hF000;
      alu_val = 8'h08;
      run_prog("t2", 0, lat, wes);
      check("t2_latency", lat, 12);
      check("t2_we_pulses", wes, 3);
      check("t2_r0", bank[0], 8'h08);

      // T3: JZ taken and not taken
      clear_rom();
      rom8[0]     = 16'h3100;
      rom8[1]     = 16'h3200;
      rom8[2]     = 16'h5300;
      rom8[3]     = 16'h7010;
      rom8[4]     = 16'hF000;
      rom8[8'h10] = 16'hF000;
      alu_val = 8'h00;
      run_prog("t3z", 0, lat, wes);
      check("t3_pc_taken", pc8, 8'h10);
      alu_val = 8'h07;
      run_prog("t3nz", 0, lat, wes);
      check("t3_pc_fall", pc8, 8'h04);

      // LDA, LDB, MOV, JMP over a skipped LDI
      clear_rom();
      rom8[0] = 16'h1A00;
      rom8[1] = 16'h2B00;
      rom8[2] = 16'h4C0A;
      rom8[3] = 16'h6005;
      rom8[4] = 16'h3FFF;
      rom8[5] = 16'hF000;
      in_a = 8'h11;
      in_b = 8'h22;
      run_prog("mix", 0, lat, wes);
      check("mix_r12", bank[12], 8'h11);
      check("mix_r15", bank[15], 8'h00);

      // T4: illegal opcode at pc 2, start held so DONE restarts at once
      clear_rom();
      rom8[2] = 16'h9000;
      rom8[3] = 16'h1400;
      rom8[4] = 16'hF000;
      in_a = 8'h44;
      run_prog("t4", 1, lat, wes);
      check("t4_illegal", ill8, 1'b1);
      check("t4_r4", bank[4], 8'h44);

      // T6: MOV R5,R5 and a start pulse while busy
      clear_rom();
      rom8[0] = 16'h355A;
      rom8[1] = 16'h4555;
      rom8[2] = 16'h0000;
      rom8[3] = 16'h0000;
      rom8[4] = 16'hF000;
      run_prog("t6", 2, lat, wes);
      check("t6_r5", bank[5], 8'h5A);
      check("t6_illegal_cleared", ill8, 1'b0);
      check("t6_pc", pc8, 8'h04);

      // T5: PC_W=4 wrap; HALT is placed at 0x1 once pc has passed it
      @(negedge clk);
      #1 start4 = 1'b1;
      n = 0;
      last = 4'h0;
      while (n < 200) begin
         @(negedge clk);
         #1 start4 = 1'b0;
         n++;
         if (busy4 && (seq.size() == 0 || pc4 != last)) begin
            seq.push_back(int'(pc4));
            last = pc4;
         end
         if (pc4 == 4'h2) rom4[1] = 16'hF000;
         if (done4) break;
      end
      check("t5_done", done4, 1'b1);
      check("t5_pc_final", pc4, 4'h1);
      check("t5_seq_len", seq.size(), 18);
      for (int j = 0; j < seq.size() && j < 18; j++)
         check($sformatf("t5_seq%0d", j), seq[j], j % 16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
